// File: rtl/seq_writer_pkg.sv
// Shared types and constants for the sequence array writer and its LFSR fill source.
// Holds the state encoding, geometry defaults, the result record and the LFSR step.
package seq_writer_pkg;

  localparam int SEQ_DEPTH  = 512;
  localparam int SEQ_ADDR_W = 9;
  localparam int SEQ_DATA_W = 16;
  localparam int RES_W      = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register sit on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] start_pos;
    logic [RES_W-1:0] length;
  } result_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/seq_lfsr16.sv
// 16-bit Fibonacci LFSR; value is valid the cycle after load, advances one step per advance.
// No backpressure: the owner holds advance low to stall the sequence.
module seq_lfsr16
  import seq_writer_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value <= LFSR_SEED;
    end else if (load) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/sequence_array_writer.sv
// Loads a sample set into the shared RAM, runs the counter unit, captures its result (SEQ_WRITER_LFSR_EN adds an LFSR fill).
// Writes land one cycle after acceptance; load_ready is low outside IDLE/WRITE, during clear and while generating.
module sequence_array_writer
  import seq_writer_pkg::*;
#(
  parameter int DEPTH  = SEQ_DEPTH,
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
`ifdef SEQ_WRITER_LFSR_EN
  input  logic              gen_start,
`endif
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic              cu_start,
  input  logic              cu_finish,
  input  logic [15:0]       cu_start_pos,
  input  logic [15:0]       cu_length,
  output logic              result_valid,
  output logic [15:0]       result_start_pos,
  output logic [15:0]       result_length,
  output logic [ADDR_W:0]   word_count,
  output logic              truncated,
  output logic              busy
);

  localparam logic [ADDR_W:0] WC_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_WC = (ADDR_W+1)'(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic                out_of_reset;
  result_t             result_q;

  logic                take;
  logic [DATA_W-1:0]   take_data;
  logic                take_last;
  logic [ADDR_W:0]     wc_next;
  logic                at_depth;
  logic                end_of_set;

  logic                gen_go;
  logic                gen_block;
  logic                gen_active;
  logic [DATA_W-1:0]   gen_data;

`ifdef SEQ_WRITER_LFSR_EN
  logic [15:0] lfsr_value;

  assign gen_go    = gen_start && (state == S_IDLE) && !clear;
  assign gen_block = gen_active || (gen_start && (state == S_IDLE));
  assign gen_data  = DATA_W'(lfsr_value);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gen_active <= 1'b0;
    end else begin
      gen_active <= gen_go || (gen_active && (state_nxt == S_WRITE));
    end
  end

  seq_lfsr16 u_lfsr (
    .clock   (clock),
    .resetn  (resetn),
    .load    (gen_go),
    .advance (take && gen_active),
    .value   (lfsr_value)
  );
`else
  assign gen_go     = 1'b0;
  assign gen_block  = 1'b0;
  assign gen_active = 1'b0;
  assign gen_data   = '0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_nxt;
      out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_ready   = 1'b0;
    take         = 1'b0;
    take_data    = load_data;
    take_last    = load_last;
    wc_next      = word_count + WC_ONE;
    at_depth     = 1'b0;
    end_of_set   = 1'b0;
    cu_start     = (state == S_RUN);
    result_valid = (state == S_DONE);
    busy         = (state != S_IDLE);

    if (state == S_IDLE) begin
      wc_next = WC_ONE;
    end
    at_depth   = (wc_next == DEPTH_WC);
    load_ready = ((state == S_IDLE) || (state == S_WRITE)) && !clear && !gen_block && out_of_reset;

    if (gen_active) begin
      take      = (state == S_WRITE) && !clear;
      take_data = gen_data;
      take_last = 1'b0;
    end else begin
      take = load_valid && load_ready;
    end
    end_of_set = take && (take_last || at_depth);

    case (state)
      S_IDLE: begin
        if (gen_go) begin
          state_nxt = S_WRITE;
        end else if (take) begin
          state_nxt = end_of_set ? S_SETTLE : S_WRITE;
        end
      end
      S_WRITE:  if (end_of_set) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_RUN;
      S_RUN:    if (cu_finish) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    if (clear) begin
      state_nxt = S_IDLE;
    end
  end

  // A generated fill starts from count 0 so its first word goes to address 0 like a loaded one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_enable  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      word_count <= '0;
      truncated  <= 1'b0;
      result_q   <= '0;
    end else begin
      wr_enable <= take;
      if (take) begin
        wr_address <= (state == S_IDLE) ? '0 : word_count[ADDR_W-1:0];
        wr_data    <= take_data;
        word_count <= wc_next;
        if (state == S_IDLE) begin
          truncated <= 1'b0;
        end
        if (at_depth && !take_last && !gen_active) begin
          truncated <= 1'b1;
        end
      end
      if (gen_go) begin
        word_count <= '0;
        truncated  <= 1'b0;
      end
      if ((state == S_RUN) && cu_finish && !clear) begin
        result_q <= '{start_pos: cu_start_pos, length: cu_length};
      end
    end
  end

  assign result_start_pos = result_q.start_pos;
  assign result_length    = result_q.length;

endmodule

// File: tb/tb_sequence_array_writer.sv
// Self-checking bench for sequence_array_writer: table vectors, random sets vs a run-length model, corner sequences.
module tb_sequence_array_writer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        clear;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;
  logic        wr_enable;
  logic [8:0]  wr_address;
  logic [15:0] wr_data;
  logic        cu_start;
  logic        cu_finish;
  logic [15:0] cu_start_pos;
  logic [15:0] cu_length;
  logic        result_valid;
  logic [15:0] result_start_pos;
  logic [15:0] result_length;
  logic [9:0]  word_count;
  logic        truncated;
  logic        busy;
`ifdef SEQ_WRITER_LFSR_EN
  logic        gen_start;
`endif

  sequence_array_writer dut (
    .clock            (clock),
    .resetn           (resetn),
    .clear            (clear),
`ifdef SEQ_WRITER_LFSR_EN
    .gen_start        (gen_start),
`endif
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .load_last        (load_last),
    .wr_enable        (wr_enable),
    .wr_address       (wr_address),
    .wr_data          (wr_data),
    .cu_start         (cu_start),
    .cu_finish        (cu_finish),
    .cu_start_pos     (cu_start_pos),
    .cu_length        (cu_length),
    .result_valid     (result_valid),
    .result_start_pos (result_start_pos),
    .result_length    (result_length),
    .word_count       (word_count),
    .truncated        (truncated),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          n;
    logic [15:0] d [8];
    logic [15:0] exp_pos;
    logic [15:0] exp_len;
  } vec_t;

  wr_t         wlog[$];
  logic [15:0] ram_model [512];
  logic [15:0] set_q[$];
  int          rv_cnt = 0;
  int          overlap_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] prev_pos = 16'd0;
  logic [15:0] prev_len = 16'd0;

  // Write monitor and protocol observer, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && wr_enable === 1'b1) begin
        wlog.push_back('{addr: wr_address, data: wr_data});
        ram_model[wr_address] = wr_data;
      end
      if (result_valid === 1'b1) rv_cnt++;
      if (result_valid === 1'b1 && cu_start === 1'b1) overlap_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Reference: longest run where each value is its predecessor plus one; 1-based start, first run wins ties.
  function automatic void longest_run(input logic [15:0] d[$], output logic [15:0] pos, output logic [15:0] len);
    int bs = 0, bl = 0, cs = 0, cl = 0;
    for (int i = 0; i < d.size(); i++) begin
      if (i > 0 && d[i] == d[i-1] + 16'd1) cl++;
      else begin
        cs = i;
        cl = 1;
      end
      if (cl > bl) begin
        bl = cl;
        bs = cs;
      end
    end
    pos = 16'(bs + 1);
    len = 16'(bl);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Load set_q, play the counter unit from the captured RAM, check writes, timing and captured result.
  task automatic do_set(input string tag, input logic [15:0] ep, input logic [15:0] el,
                        input int lat, input int gap_pct);
    int acc = 0, last_acc = 0, guard = 0, bad = 0, rv0;
    logic [15:0] q[$];
    logic [15:0] pos, len;
    wlog.delete();
    rv0 = rv_cnt;
    while (acc < set_q.size() && guard < 2000) begin
      load_valid = ($urandom_range(99) >= gap_pct);
      load_data  = set_q[acc];
      load_last  = (acc == set_q.size() - 1);
      #1;
      if (load_valid && load_ready) begin
        acc++;
        last_acc = cyc;
      end
      tick();
      guard++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check({tag, "_accepted"}, acc, set_q.size());
    guard = 0;
    while (cu_start !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_start_cycle"}, cyc, last_acc + 2);
    if (wlog.size() != set_q.size()) bad++;
    for (int i = 0; i < wlog.size() && i < set_q.size(); i++)
      if (wlog[i].addr != 9'(i) || wlog[i].data != set_q[i]) bad++;
    check({tag, "_writes"}, bad, 0);
    check({tag, "_word_count"}, word_count, set_q.size());
    check({tag, "_truncated"}, truncated, 0);
    for (int i = 0; i < set_q.size(); i++) q.push_back(ram_model[i]);
    longest_run(q, pos, len);
    repeat (lat) tick();
    cu_finish    = 1'b1;
    cu_start_pos = pos;
    cu_length    = len;
    tick();
    cu_finish    = 1'b0;
    cu_start_pos = ~pos;
    cu_length    = ~len;
    check({tag, "_result_valid"}, result_valid, 1);
    check({tag, "_cu_start_low"}, cu_start, 0);
    check({tag, "_pos"}, result_start_pos, ep);
    check({tag, "_len"}, result_length, el);
    tick();
    check({tag, "_ready_after"}, {load_ready, result_valid, busy}, 3'b100);
    check({tag, "_rv_pulses"}, rv_cnt - rv0, 1);
    prev_pos = ep;
    prev_len = el;
  endtask

  vec_t tbl [6];

  initial begin
    int acc, late, bad, rv0, p, guard;
    logic [15:0] ep, el, v, s;

    tbl[0] = '{5, '{16'd3, 16'd4, 16'd5, 16'd9, 16'd1, 16'd0, 16'd0, 16'd0}, 16'd1, 16'd3};
    tbl[1] = '{1, '{16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 16'd1, 16'd1};
    tbl[2] = '{8, '{16'd10, 16'd11, 16'd12, 16'd13, 16'd2, 16'd3, 16'd4, 16'd5}, 16'd1, 16'd4};
    tbl[3] = '{6, '{16'd9, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0}, 16'd2, 16'd4};
    tbl[4] = '{4, '{16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0}, 16'd1, 16'd1};
    tbl[5] = '{8, '{16'd0, 16'd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd9}, 16'd3, 16'd5};

    resetn = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    cu_finish = 1'b0; cu_start_pos = '0; cu_length = '0;
`ifdef SEQ_WRITER_LFSR_EN
    gen_start = 1'b0;
`endif
    repeat (3) tick();
    check("reset_ready", load_ready, 0);
    check("reset_wr", {wr_enable, wr_address, wr_data}, 0);
    check("reset_ctl", {cu_start, result_valid, busy, truncated}, 0);
    check("reset_result", {result_start_pos, result_length}, 0);
    check("reset_word_count", word_count, 0);
    resetn = 1'b1;
    tick();
    tick();
    check("idle_ready", {load_ready, busy}, 2'b10);

    for (int k = 0; k < 6; k++) begin
      set_q.delete();
      for (int i = 0; i < tbl[k].n; i++) set_q.push_back(tbl[k].d[i]);
      do_set($sformatf("vec%0d", k), tbl[k].exp_pos, tbl[k].exp_len, k % 3, (k == 0) ? 0 : 30);
    end

    for (int r = 0; r < 15; r++) begin
      set_q.delete();
      v = 16'($urandom_range(0, 15));
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
        set_q.push_back(v);
        v = ($urandom_range(0, 9) < 6) ? v + 16'd1 : 16'($urandom_range(0, 15));
      end
      longest_run(set_q, ep, el);
      do_set($sformatf("rnd%0d", r), ep, el, int'($urandom_range(0, 4)), int'($urandom_range(0, 50)));
    end

    // 600 offered samples with no last marker: only DEPTH land.
    wlog.delete();
    acc = 0; late = 0; bad = 0;
    for (int i = 0; i < 600; i++) begin
      load_valid = 1'b1;
      load_data  = 16'(acc);
      load_last  = 1'b0;
      #1;
      if (load_ready) begin
        if (acc >= 512) late++;
        acc++;
      end
      tick();
    end
    load_valid = 1'b0;
    check("trunc_accepted", acc, 512);
    check("trunc_late_ready", late, 0);
    if (wlog.size() != 512) bad++;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i].addr != 9'(i) || wlog[i].data != 16'(i)) bad++;
    check("trunc_writes", bad, 0);
    check("trunc_flag", truncated, 1);
    check("trunc_word_count", word_count, 512);
    check("trunc_in_run", cu_start, 1);

    // Abort from RUN.
    rv0 = rv_cnt;
    clear = 1'b1;
    #1;
    check("clear_run_ready", load_ready, 0);
    tick();
    clear = 1'b0;
    check("clear_run_start", {cu_start, busy}, 2'b00);
    check("clear_run_result", {result_start_pos, result_length}, {prev_pos, prev_len});
    check("clear_run_kept", {word_count, truncated}, {10'd512, 1'b1});
    repeat (3) tick();
    check("clear_run_no_rv", rv_cnt - rv0, 0);

    // Clear collides with an offered sample in WRITE.
    wlog.delete();
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 16'(i + 1);
      #1;
      if (load_ready) acc++;
      tick();
    end
    check("clrw_accepted", acc, 3);
    clear = 1'b1;
    load_data = 16'hDEAD;
    #1;
    check("clrw_ready", load_ready, 0);
    tick();
    clear = 1'b0;
    load_valid = 1'b0;
    check("clrw_no_write", wr_enable, 0);
    check("clrw_state", {word_count, busy, truncated}, {10'd3, 1'b0, 1'b0});
    tick();
    check("clrw_log", wlog.size(), 3);

    // Stray finish while idle.
    rv0 = rv_cnt;
    cu_finish = 1'b1;
    tick();
    cu_finish = 1'b0;
    check("idle_finish", {busy, result_valid}, 2'b00);
    tick();
    check("idle_finish_rv", rv_cnt - rv0, 0);

    // Two sets back to back.
    set_q.delete();
    for (int i = 0; i < 4; i++) set_q.push_back(16'(20 + i));
    do_set("b2b_a", 16'd1, 16'd4, 0, 0);
    set_q.delete();
    for (int i = 0; i < 3; i++) set_q.push_back(16'(40 - i));
    do_set("b2b_b", 16'd1, 16'd1, 0, 0);
    check("start_rv_overlap", overlap_cnt, 0);

`ifdef SEQ_WRITER_LFSR_EN
    wlog.delete();
    gen_start = 1'b1;
    p = cyc;
    tick();
    gen_start = 1'b0;
    load_valid = 1'b1;
    #1;
    check("gen_ready", load_ready, 0);
    load_valid = 1'b0;
    guard = 0;
    while (cu_start !== 1'b1 && guard < 700) begin
      tick();
      guard++;
    end
    check("gen_start_cycle", cyc, p + 514);
    check("gen_count", wlog.size(), 512);
    if (wlog.size() >= 2) begin
      check("gen_word0", wlog[0].data, 16'hACE1);
      check("gen_word1", wlog[1].data, 16'h5670);
    end
    bad = 0;
    s = 16'hACE1;
    for (int i = 0; i < wlog.size(); i++) begin
      if (wlog[i].addr != 9'(i) || wlog[i].data != s) bad++;
      s = lfsr_next(s);
    end
    check("gen_sequence", bad, 0);
    check("gen_flags", {word_count, truncated}, {10'd512, 1'b0});
    cu_finish = 1'b1;
    tick();
    cu_finish = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequence_array_writer.md
# sequence_array_writer

Front-end initiator for the longest-consecutive-run counter unit. Accepts a stream of 16-bit samples, writes them into the shared 512x16 on-chip RAM through its write port, then holds `cu_start` high until the counter raises `cu_finish`. It captures the reported start position and length and presents them once to the processor-side logic. It sits between the Avalon/PIO register block and the counter unit and owns the RAM write port exclusively.

## Interface
- DEPTH, 512, number of RAM words; must equal 2**ADDR_W
- ADDR_W, 9, RAM address width
- DATA_W, 16, sample width
- clock  in  1  system clock; all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort; returns to IDLE from any state
- load_valid  in  1  sample present on load_data
- load_ready  out  1  writer accepts a sample this cycle
- load_data  in  DATA_W  sample value
- load_last  in  1  qualifies the final sample of a set
- wr_enable  out  1  RAM write strobe
- wr_address  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- cu_start  out  1  level start to the counter unit
- cu_finish  in  1  counter-unit completion flag
- cu_start_pos  in  16  counter-unit result: run start index
- cu_length  in  16  counter-unit result: run length
- result_valid  out  1  one-cycle pulse; result registers updated
- result_start_pos  out  16  captured start position
- result_length  out  16  captured length
- word_count  out  ADDR_W+1  words written in the current or last set (1..DEPTH)
- truncated  out  1  set ended at DEPTH words without load_last
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WRITE, SETTLE, RUN, DONE.
- `load_ready` = (state is IDLE or WRITE) and not `clear`.
- IDLE: the first accepted sample resets `word_count` to 1 and `truncated` to 0, then moves to WRITE (or SETTLE if `load_last` is high).
- WRITE: each accepted sample is written at address `word_count`-1, and `word_count` increments. Addresses start at 0 and never wrap.
- End of set: the accepted sample has `load_last` = 1, or it is the DEPTH-th word. The DEPTH-th word without `load_last` sets `truncated` = 1. In both cases the state moves to SETTLE.
- SETTLE: lasts 1 cycle so the final write is committed before the counter reads address 0. Then moves to RUN.
- RUN: `cu_start` = 1. When `cu_finish` = 1, `cu_start_pos` and `cu_length` are latched into the result registers, and the state moves to DONE.
- DONE: `cu_start` = 0 and `result_valid` = 1 for this cycle only. Then moves to IDLE. The counter therefore sees at least 1 low cycle of `cu_start` before any new run.
- `cu_finish` outside RUN is ignored.
- `clear` has priority over everything:
  - next state is IDLE; `cu_start` and `wr_enable` are 0 the next cycle;
  - a sample offered in the same cycle is not accepted;
  - the result registers, `word_count` and `truncated` are kept.
- Result registers hold their value until the next DONE.

## Timing
- Reset values: `load_ready`=0 during reset, 1 once IDLE is active after release. `wr_enable`=0, `wr_address`=0, `wr_data`=0, `cu_start`=0, `result_valid`=0, `result_start_pos`=0, `result_length`=0, `word_count`=0, `truncated`=0, `busy`=0.
- `wr_*` are registered: a sample accepted in cycle t is written with `wr_enable`=1 in cycle t+1.
- If the last sample is accepted in cycle t: t+1 is the final write and SETTLE, and `cu_start` rises in t+2.
- If `cu_finish` is sampled high in cycle f: `result_valid`=1 and `cu_start`=0 in f+1, and `load_ready`=1 in f+2.
- Back-to-back samples are accepted at 1 per cycle with no bubbles.

## Configuration
- `SEQ_WRITER_LFSR_EN`
- Defined:
  - adds input `gen_start`; a 1-cycle pulse in IDLE fills all DEPTH words from an internal 16-bit Fibonacci LFSR;
  - LFSR taps are 16,14,13,11; the seed is 16'hACE1 and is reloaded on reset and on each `gen_start`;
  - one word per cycle, then SETTLE and RUN as normal; `truncated` stays 0;
  - `load_ready` is 0 while generating.
- Undefined: no `gen_start` port and no LFSR logic.

## Structure
- Package `seq_writer_pkg`: the state enum, DEPTH/ADDR_W defaults, and the LFSR seed and tap constants.
- Sub-module `seq_lfsr16`: free-running LFSR with load and advance enables. It is instantiated only under `SEQ_WRITER_LFSR_EN`.

## Test plan
- Write 5 samples {3,4,5,9,1} with `load_last` on the 5th: addresses 0..4 written; `cu_start` rises 2 cycles after the 5th acceptance; a model counter returns (1,3); `result_start_pos`=1, `result_length`=3, with a single `result_valid` pulse.
- Stream 600 samples with no `load_last`: exactly 512 are written (addresses 0..511), `truncated`=1, `word_count`=512, and `load_ready`=0 from the 513th sample onward.
- Assert `clear` in RUN: `cu_start`=0 the next cycle, state returns to IDLE, no `result_valid`, previous results unchanged.
- Assert `clear` and `load_valid` in the same cycle in WRITE: the sample is not written and `word_count` is unchanged.
- Pulse `cu_finish` while in IDLE: no state change and no `result_valid`. Then run two consecutive sets: `cu_start` is low for at least 1 cycle between runs.
- With `SEQ_WRITER_LFSR_EN` defined, pulse `gen_start`: 512 writes occur, the first two words are 16'hACE1 and its LFSR successor, and `cu_start` rises in cycle 514 after the pulse.
